pc_sequencer: RTL and testbench

//  Parametrised program-counter sequencer replacing the fixed +4 PC register.

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch with handshake, branch/jump redirects, flush pulse.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
  parameter int                   PC_WIDTH     = 32,
  parameter int                   STEP         = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                   OFF_WIDTH    = 8,
  parameter int                   RAS_DEPTH    = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        IF_READY,
  input  logic                        STALL,
  input  logic                        BRANCH_TAKEN,
  input  logic signed [OFF_WIDTH-1:0] BRANCH_OFFSET,
  input  logic                        JUMP_EN,
  input  logic [PC_WIDTH-1:0]         JUMP_TARGET,
  input  logic                        HALT,
  input  logic                        CALL,
  input  logic                        RET,
  output logic [PC_WIDTH-1:0]         PC,
  output logic                        PC_VALID,
  output logic                        REDIRECT,
  output logic                        RAS_EMPTY
);

  localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(STEP);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t              state_q, state_n;
  logic [PC_WIDTH-1:0] pc_q, pc_n;
  logic                redirect_q, redirect_n;
  logic                ret_ok;
  logic [PC_WIDTH-1:0] ras_top;

  // Offset counts instructions: sign-extend to full width first, then scale to bytes.
  function automatic logic [PC_WIDTH-1:0] branch_target(
    input logic [PC_WIDTH-1:0]         pc,
    input logic signed [OFF_WIDTH-1:0] off
  );
    logic signed [PC_WIDTH-1:0] disp;
    disp = PC_WIDTH'(off);
    disp = disp <<< 2;
    return pc + STEP_V + $unsigned(disp);
  endfunction

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]       top_q;
  logic [PW:0]         count_q;
  logic                push, pop;

  assign ret_ok    = RET && (count_q != '0);
  assign ras_top   = ras[top_q - 1'b1];
  assign RAS_EMPTY = (count_q == '0);

  // Circular stack: top_q is the next write slot, so a push when full overwrites the oldest entry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (pop) begin
      top_q   <= top_q - 1'b1;
      count_q <= count_q - 1'b1;
    end else if (push) begin
      top_q <= top_q + 1'b1;
      if (count_q != RAS_FULL) count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RESET) ras[top_q] <= pc_q + STEP_V;
  end
`else
  logic unused_ras;
  assign unused_ras = CALL | RET;
  assign ret_ok     = 1'b0;
  assign ras_top    = '0;
  assign RAS_EMPTY  = 1'b1;
`endif

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    redirect_n = 1'b0;
`ifdef PC_RAS_EN
    push       = 1'b0;
    pop        = 1'b0;
`endif
    case (state_q)
      BOOT:   state_n = RUN;
      RUN: begin
        if (HALT) begin
          state_n = HALTED;
        end else if (ret_ok) begin
          pc_n       = ras_top;
          redirect_n = 1'b1;
`ifdef PC_RAS_EN
          pop        = 1'b1;
`endif
        end else if (JUMP_EN) begin
          pc_n       = JUMP_TARGET;
          redirect_n = 1'b1;
`ifdef PC_RAS_EN
          push       = CALL;
`endif
        end else if (BRANCH_TAKEN) begin
          pc_n       = branch_target(pc_q, BRANCH_OFFSET);
          redirect_n = 1'b1;
        end else if (IF_READY && !STALL) begin
          pc_n = pc_q + STEP_V;
        end
      end
      default: state_n = state_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      redirect_q <= redirect_n;
    end
  end

  assign PC       = pc_q;
  assign PC_VALID = (state_q == RUN);
  assign REDIRECT = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with a queue-based scoreboard.
// Covers the return-address stack when PC_RAS_EN is defined, otherwise checks it is inert.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RESET, IF_READY, STALL, BRANCH_TAKEN, JUMP_EN, HALT, CALL, RET;
  logic signed [7:0] BRANCH_OFFSET;
  logic [31:0] JUMP_TARGET;
  logic [31:0] PC;
  logic        PC_VALID, REDIRECT, RAS_EMPTY;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        v;
    logic        r;
    logic        e;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .RESET(RESET), .IF_READY(IF_READY), .STALL(STALL),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_OFFSET(BRANCH_OFFSET),
    .JUMP_EN(JUMP_EN), .JUMP_TARGET(JUMP_TARGET), .HALT(HALT),
    .CALL(CALL), .RET(RET), .PC(PC), .PC_VALID(PC_VALID),
    .REDIRECT(REDIRECT), .RAS_EMPTY(RAS_EMPTY)
  );

  // Monitor: every edge that has a queued expectation is checked 1 time unit later.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (PC !== e.pc || PC_VALID !== e.v || REDIRECT !== e.r || RAS_EMPTY !== e.e) begin
        n_fail++;
        $display("FAIL %s: got pc=%h valid=%b redirect=%b ras_empty=%b, need pc=%h valid=%b redirect=%b ras_empty=%b",
                 e.name, PC, PC_VALID, REDIRECT, RAS_EMPTY, e.pc, e.v, e.r, e.e);
      end
    end
  end

  task automatic vec(input string name,
                     input logic rst, input logic ifr, input logic stl,
                     input logic br, input logic [7:0] off,
                     input logic jmp, input logic [31:0] tgt,
                     input logic hlt, input logic cl, input logic rt,
                     input logic [31:0] epc, input logic ev, input logic er, input logic ee);
    exp_t e;
    @(negedge CLK);
    RESET = rst; IF_READY = ifr; STALL = stl; BRANCH_TAKEN = br;
    BRANCH_OFFSET = off; JUMP_EN = jmp; JUMP_TARGET = tgt;
    HALT = hlt; CALL = cl; RET = rt;
    e.name = name; e.pc = epc; e.v = ev; e.r = er; e.e = ee;
    exp_q.push_back(e);
    @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1; IF_READY = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0;
    BRANCH_OFFSET = '0; JUMP_EN = 1'b0; JUMP_TARGET = '0;
    HALT = 1'b0; CALL = 1'b0; RET = 1'b0;

    //   name        rst ifr stl br off    jmp tgt            hlt cl rt   pc             v  r  e
    vec("rst0",      1, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         0, 0, 1);
    vec("rst1",      1, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         0, 0, 1);
    vec("boot",      0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         1, 0, 1);
    vec("seq4",      0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h4,         1, 0, 1);
    vec("seq8",      0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h8,         1, 0, 1);
    vec("stall_a",   0, 1, 1, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h8,         1, 0, 1);
    vec("stall_b",   0, 1, 1, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h8,         1, 0, 1);
    vec("stall_c",   0, 1, 1, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h8,         1, 0, 1);
    vec("br_back",   0, 1, 1, 1, 8'hFE, 0, 32'h0,          0, 0, 0,  32'h4,         1, 1, 1);
    vec("after_br",  0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h8,         1, 0, 1);
    vec("seq12",     0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'hC,         1, 0, 1);
    vec("ifr_low",   0, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'hC,         1, 0, 1);
    vec("jmp_wins",  0, 1, 0, 1, 8'h03, 1, 32'h100,        0, 0, 0,  32'h100,       1, 1, 1);
    vec("br_m1",     0, 0, 0, 1, 8'hFF, 0, 32'h0,          0, 0, 0,  32'h100,       1, 1, 1);
    vec("br_fwd",    0, 0, 0, 1, 8'h02, 0, 32'h0,          0, 0, 0,  32'h10C,       1, 1, 1);
    vec("jmp_top",   0, 0, 0, 0, 8'h00, 1, 32'hFFFF_FFFC,  0, 0, 0,  32'hFFFF_FFFC, 1, 1, 1);
    vec("wrap",      0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         1, 0, 1);
    vec("jmp_40",    0, 0, 0, 0, 8'h00, 1, 32'h40,         0, 0, 0,  32'h40,        1, 1, 1);
    vec("rst_mid",   1, 1, 0, 0, 8'h00, 1, 32'h999,        0, 0, 0,  32'h0,         0, 0, 1);
    vec("reboot",    0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         1, 0, 1);
    vec("jmp_odd",   0, 1, 0, 0, 8'h00, 1, 32'h23,         0, 0, 0,  32'h23,        1, 1, 1);
    vec("jmp_20",    0, 1, 0, 0, 8'h00, 1, 32'h20,         0, 0, 0,  32'h20,        1, 1, 1);
    vec("halt",      0, 1, 0, 0, 8'h00, 1, 32'h500,        1, 0, 0,  32'h20,        0, 0, 1);
    vec("halted",    0, 1, 0, 1, 8'h04, 1, 32'h500,        0, 0, 0,  32'h20,        0, 0, 1);
    vec("halted2",   0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h20,        0, 0, 1);
    vec("rst_halt",  1, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         0, 0, 1);
    vec("boot2",     0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 0,  32'h0,         1, 0, 1);
`ifdef PC_RAS_EN
    vec("jmp_10",    0, 0, 0, 0, 8'h00, 1, 32'h10,         0, 0, 0,  32'h10,        1, 1, 1);
    vec("call",      0, 0, 0, 0, 8'h00, 1, 32'h80,         0, 1, 0,  32'h80,        1, 1, 0);
    vec("ret",       0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h14,        1, 1, 1);
    vec("ret_empty", 0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h18,        1, 0, 1);
    vec("call1",     0, 0, 0, 0, 8'h00, 1, 32'h100,        0, 1, 0,  32'h100,       1, 1, 0);
    vec("call2",     0, 0, 0, 0, 8'h00, 1, 32'h200,        0, 1, 0,  32'h200,       1, 1, 0);
    vec("call3",     0, 0, 0, 0, 8'h00, 1, 32'h300,        0, 1, 0,  32'h300,       1, 1, 0);
    vec("call4",     0, 0, 0, 0, 8'h00, 1, 32'h400,        0, 1, 0,  32'h400,       1, 1, 0);
    vec("call5",     0, 0, 0, 0, 8'h00, 1, 32'h500,        0, 1, 0,  32'h500,       1, 1, 0);
    vec("ret1",      0, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h404,       1, 1, 0);
    vec("ret2",      0, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h304,       1, 1, 0);
    vec("ret3",      0, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h204,       1, 1, 0);
    vec("ret4",      0, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h104,       1, 1, 1);
    vec("ret5_ign",  0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h108,       1, 0, 1);
    vec("call6",     0, 0, 0, 0, 8'h00, 1, 32'h600,        0, 1, 0,  32'h600,       1, 1, 0);
    vec("call_ret",  0, 0, 0, 0, 8'h00, 1, 32'h700,        0, 1, 1,  32'h10C,       1, 1, 1);
    vec("ret_none",  0, 0, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h10C,       1, 0, 1);
`else
    vec("ret_ign",   0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h4,         1, 0, 1);
    vec("call_ign",  0, 0, 0, 0, 8'h00, 1, 32'h80,         0, 1, 0,  32'h80,        1, 1, 1);
    vec("ret_ign2",  0, 1, 0, 0, 8'h00, 0, 32'h0,          0, 0, 1,  32'h84,        1, 0, 1);
`endif
    vec("idle",      0, 0, 0, 0, 8'h00, 0, 32'h0,          1, 0, 0,  PC_FINAL(),    0, 0, 1);

    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // PC frozen by the final HALT: the address the preceding vector left behind.
  function automatic logic [31:0] PC_FINAL();
`ifdef PC_RAS_EN
    return 32'h10C;
`else
    return 32'h84;
`endif
  endfunction

endmodule
